wbm_spi_cmd: RTL and testbench
==============================

Name: wbm_spi_cmd

Overview:
- Wishbone-domain consumer of bytes received by the SPI slave receive stage.
- Imports each byte over the 4-phase valid/ack handshake and decodes a 1- or 2-byte command.
- Runs one classic Wishbone master cycle per command and hands read data to the SPI transmit stage over valid/ready.

Parameters:
- ADDR_W, 4, Wishbone word-address width (1..6); taken from command bits [ADDR_W-1:0].
- SYNC_STAGES, 2, flip-flop stages on handshake_valid (min 2).
- TIMEOUT, 255, wb_ack_i wait limit in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  Wishbone clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- handshake_valid  in  1  byte-available level from the SPI clock domain, asynchronous to clk.
- handshake_data  in  8  received byte; stable while handshake_valid is high.
- handshake_ack  out  1  4-phase acknowledge back to the SPI clock domain.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  write enable.
- wbm_adr_o  out  ADDR_W  word address.
- wbm_dat_o  out  8  write data.
- wbm_dat_i  in  8  read data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- rsp_valid  out  1  response byte available to the transmit stage.
- rsp_data  out  8  response byte.
- rsp_ready  in  1  transmit stage accepts rsp_data.

Behaviour:
- Reset (async, rst_n=0): handshake_ack=0, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_adr_o=0, wbm_dat_o=0, rsp_valid=0, rsp_data=0, state=IDLE, synchronizer cleared.
  - Mid-cycle reset drops cyc/stb immediately; any pending byte is discarded.
- Import:
  - handshake_valid passes through SYNC_STAGES flip-flops to give vsync.
  - When vsync=1, handshake_ack=0 and state is IDLE or WDATA: capture handshake_data, pulse internal byte_stb for 1 cycle, set handshake_ack=1 on the next edge.
  - handshake_ack holds at 1 until vsync=0, then clears.
  - A new byte is accepted only after the ack drops.
  - Latency from handshake_valid rising to byte_stb is SYNC_STAGES+1 clk cycles.
  - In WB or RSP no byte is accepted and ack stays 0, so the producer sees backpressure.
- Command byte [7:6]:
  - 00 = NOP, ignored.
  - 01 = read.
  - 10 = write.
  - 11 = reserved, ignored.
  - [5:0] = address; bits above ADDR_W are ignored.
- FSM (one-hot or encoded):
  - IDLE:
    - byte_stb with read: latch adr, we=0, go to WB.
    - byte_stb with write: latch adr, go to WDATA.
    - Otherwise stay in IDLE.
  - WDATA: next byte_stb latches wbm_dat_o, sets we=1, goes to WB. Any byte value is taken as data, including 0x00.
  - WB:
    - cyc=stb=1 from the cycle after entry.
    - On wbm_ack_i: cyc=stb=0 on the next edge.
    - Read: latch wbm_dat_i into rsp_data and go to RSP.
    - Write: go to IDLE. Writes produce no response.
    - ack asserted on the same cycle stb rises is valid; single beat, no retry.
  - RSP:
    - rsp_valid=1 with rsp_data held until rsp_ready=1.
    - Transfer occurs on the edge where valid&ready; rsp_valid=0 on the next cycle; go to IDLE.
    - rsp_ready=1 on the entry cycle completes in 1 cycle.
- wbm_adr_o and wbm_dat_o hold their last values while idle.
- wbm_we_o returns to 0 when cyc drops.

Optional Feature:
- Macro WBM_SPI_CMD_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter (clog2(TIMEOUT+1) bits) runs while in WB.
  - If TIMEOUT cycles pass without wbm_ack_i: drop cyc/stb.
  - Read: go to RSP with rsp_data=8'hFF. Write: go to IDLE.
  - An ack on the same cycle the counter expires wins.
- Undefined: no counter; WB waits for wbm_ack_i indefinitely.

Decomposition:
- Package wbm_spi_pkg holds:
  - opcode constants OP_NOP=2'b00, OP_READ=2'b01, OP_WRITE=2'b10.
  - FSM state encoding ST_IDLE, ST_WDATA, ST_WB, ST_RSP.
  - TIMEOUT_BYTE=8'hFF.
- One sub-module, wbm_spi_import: synchronizer, capture register, ack logic and byte_stb generation, parameterised by SYNC_STAGES and SIZE=8.

Test Plan:
- Read: bytes 0x43, reg[3]=0x5A, ack after 2 cycles -> one cycle with cyc/stb=1, we=0, adr=3; then rsp_valid, rsp_data=0x5A; one handshake_ack pulse per byte.
- Write: bytes 0x85 then 0xC3 -> we=1, adr=5, dat_o=0xC3; rsp_valid never asserts; slave register reads back 0xC3.
- NOP and reserved: bytes 0x00, 0xFF, 0x3F -> each acked; no cyc; FSM stays IDLE.
- Backpressure: rsp_ready=0 for 20 cycles after a read -> rsp_valid/rsp_data stable; next handshake_valid not acked until transfer; ready=1 -> accepted, then IDLE.
- Reset mid-cycle: rst_n=0 while cyc=1 -> cyc, stb, ack and rsp_valid at 0 immediately; after release, a fresh read command 0x41 completes normally.
- Timeout (macro defined, TIMEOUT=16): read 0x42 with no slave ack -> cyc drops after 16 cycles; rsp_data=0xFF. Macro undefined -> cyc still high after 1000 cycles.

Source files
------------

// File: rtl/wbm_spi_cmd_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the SPI command Wishbone master.
package wbm_spi_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  localparam logic [7:0] TIMEOUT_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_WB    = 2'd2,
    ST_RSP   = 2'd3
  } state_t;

  // Timeout counter is never narrower than a byte.
  function automatic int tmo_width(input int t);
    int w;
    w = $clog2(t + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/wbm_spi_cmd_import.sv
// Pulls bytes across from the SPI clock domain: level synchronizer, capture register,
// 4-phase ack and a one-cycle byte strobe. i_en gates acceptance (backpressure).
module wbm_spi_import
  import wbm_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SIZE        = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [SIZE-1:0] i_data,
  input  logic            i_en,
  output logic            o_ack,
  output logic            o_stb,
  output logic [SIZE-1:0] o_data
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ack;
  logic                   r_stb;
  logic [SIZE-1:0]        r_data;
  logic                   w_vsync;

  assign w_vsync = r_sync[SYNC_STAGES-1];
  assign o_ack   = r_ack;
  assign o_stb   = r_stb;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_ack  <= 1'b0;
      r_stb  <= 1'b0;
      r_data <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_valid};
      r_stb  <= 1'b0;
      // Data is stable while valid is high, so sampling on vsync is safe.
      if (r_ack) begin
        if (!w_vsync) r_ack <= 1'b0;
      end else if (w_vsync && i_en) begin
        r_data <= i_data;
        r_stb  <= 1'b1;
        r_ack  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/wbm_spi_cmd.sv
// SPI command decoder driving one classic Wishbone cycle per read/write command.
// Optional WB ack timeout enabled by defining WBM_SPI_CMD_TIMEOUT_EN.
module wbm_spi_cmd
  import wbm_spi_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              handshake_valid,
  input  logic [7:0]        handshake_data,
  output logic              handshake_ack,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [7:0]        wbm_dat_o,
  input  logic [7:0]        wbm_dat_i,
  input  logic              wbm_ack_i,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  input  logic              rsp_ready
);

  state_t            r_state;
  logic              r_cyc;
  logic              r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [7:0]        r_dat;
  logic              r_rsp_valid;
  logic [7:0]        r_rsp;

  logic              w_accept;
  logic              w_byte_stb;
  logic [7:0]        w_byte;
  logic              w_expire;
  logic              w_done;
  logic [7:0]        w_rdat;

  assign w_accept = (r_state == ST_IDLE) || (r_state == ST_WDATA);

  wbm_spi_import #(
    .SYNC_STAGES (SYNC_STAGES),
    .SIZE        (8)
  ) u_import (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (handshake_valid),
    .i_data  (handshake_data),
    .i_en    (w_accept),
    .o_ack   (handshake_ack),
    .o_stb   (w_byte_stb),
    .o_data  (w_byte)
  );

`ifdef WBM_SPI_CMD_TIMEOUT_EN
  localparam int TW = tmo_width(TIMEOUT);
  logic [TW-1:0] r_tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_tmo <= '0;
    else if (r_state != ST_WB) r_tmo <= '0;
    else                       r_tmo <= r_tmo + 1'b1;
  end

  assign w_expire = (r_state == ST_WB) && (r_tmo == TW'(TIMEOUT - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT != 0);
  assign w_expire     = 1'b0;
`endif

  // A real ack wins over a simultaneous expiry.
  assign w_done = wbm_ack_i | w_expire;
  assign w_rdat = wbm_ack_i ? wbm_dat_i : TIMEOUT_BYTE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_byte_stb) begin
            if (w_byte[7:6] == OP_READ) begin
              r_adr   <= w_byte[ADDR_W-1:0];
              r_we    <= 1'b0;
              r_cyc   <= 1'b1;
              r_state <= ST_WB;
            end else if (w_byte[7:6] == OP_WRITE) begin
              r_adr   <= w_byte[ADDR_W-1:0];
              r_state <= ST_WDATA;
            end
          end
        end
        ST_WDATA: begin
          if (w_byte_stb) begin
            r_dat   <= w_byte;
            r_we    <= 1'b1;
            r_cyc   <= 1'b1;
            r_state <= ST_WB;
          end
        end
        ST_WB: begin
          if (w_done) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            if (!r_we) begin
              r_rsp       <= w_rdat;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RSP;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp;

endmodule

// File: tb/tb_wbm_spi_cmd.sv
// Bench for wbm_spi_cmd: directed vector table, random commands vs a memory model,
// plus backpressure, timeout/no-timeout and mid-cycle reset sequences.
module tb_wbm_spi_cmd;

  localparam int AW  = 4;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          handshake_valid = 1'b0;
  logic [7:0]    handshake_data = 8'h00;
  logic          handshake_ack;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [AW-1:0] wbm_adr_o;
  logic [7:0]    wbm_dat_o, wbm_dat_i;
  logic          wbm_ack_i;
  logic          rsp_valid;
  logic [7:0]    rsp_data;
  logic          rsp_ready;

  always #5 clk = ~clk;

  wbm_spi_cmd #(.ADDR_W(AW), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .handshake_valid(handshake_valid), .handshake_data(handshake_data),
    .handshake_ack(handshake_ack),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response sink: fixed or random ready.
  bit rnd_mode = 1'b0;
  bit rdy_val  = 1'b1;
  bit rnd_bit  = 1'b0;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
  assign rsp_ready = rnd_mode ? rnd_bit : rdy_val;

  // Wishbone slave: register file with programmable ack delay.
  logic [7:0] init_mem [16];
  logic [7:0] slv_mem  [16];
  logic [7:0] mdl_mem  [16];
  bit         load_mem = 1'b0;
  bit         slv_en   = 1'b1;
  int         slv_dly  = 2;
  int         slv_cnt  = 0;

  always @(posedge clk) slv_cnt <= wbm_cyc_o ? slv_cnt + 1 : 0;
  assign wbm_ack_i = wbm_cyc_o & wbm_stb_o & slv_en & (slv_cnt >= slv_dly);
  assign wbm_dat_i = slv_mem[wbm_adr_o];

  typedef struct {
    logic       we;
    logic [3:0] adr;
    logic [7:0] dat;
    int         ncyc;
  } txn_t;

  txn_t       wb_q[$];
  logic [7:0] rsp_q[$];
  int         wb_rd = 0, rsp_rd = 0;
  int         cyc_run = 0, ack_rises = 0, bytes_sent = 0;
  logic       ack_d = 1'b0;

  always @(negedge clk) begin
    if (load_mem) slv_mem = init_mem;
    if (wbm_cyc_o) cyc_run++;
    if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
      wb_q.push_back('{wbm_we_o, wbm_adr_o, wbm_dat_o, cyc_run});
      if (wbm_we_o) slv_mem[wbm_adr_o] = wbm_dat_o;
    end
    if (!wbm_cyc_o || wbm_ack_i) cyc_run = 0;
    if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_data);
    if (handshake_ack && !ack_d) ack_rises++;
    ack_d = handshake_ack;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    handshake_data  = b;
    handshake_valid = 1'b1;
    bytes_sent++;
    n = 0;
    while (!handshake_ack && n < 400) begin @(negedge clk); n++; end
    check("hs ack rise", handshake_ack, 1);
    handshake_valid = 1'b0;
    n = 0;
    while (handshake_ack && n < 50) begin @(negedge clk); n++; end
    check("hs ack fall", handshake_ack, 0);
  endtask

  task automatic issue(input logic [7:0] c, input logic [7:0] d);
    send_byte(c);
    if (c[7:6] == 2'b10) send_byte(d);
  endtask

  task automatic settle(input int nwb, input int nrsp);
    int n;
    n = 0;
    while ((wb_q.size() < wb_rd + nwb || rsp_q.size() < rsp_rd + nrsp) && n < 400) begin
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
  endtask

  // Reference: command semantics applied to a plain memory array.
  task automatic model(input logic [7:0] c, input logic [7:0] d, output int nwb,
                       output logic we, output logic [3:0] adr, output int nrsp,
                       output logic [7:0] rsp);
    int op, a;
    op   = int'(c) / 64;
    a    = (int'(c) % 64) % (1 << AW);
    nwb  = 0; nrsp = 0; we = 1'b0; adr = 4'(a); rsp = 8'h00;
    if (op == 1) begin
      nwb = 1; nrsp = 1; rsp = mdl_mem[a];
    end else if (op == 2) begin
      nwb = 1; we = 1'b1; mdl_mem[a] = d;
    end
  endtask

  task automatic compare(input string tag, input int nwb, input logic we, input logic [3:0] adr,
                         input logic [7:0] dat, input int nrsp, input logic [7:0] rsp);
    txn_t t;
    check({tag, " wb count"}, wb_q.size() - wb_rd, nwb);
    if (nwb == 1 && wb_q.size() > wb_rd) begin
      t = wb_q[wb_rd];
      check({tag, " we"}, t.we, we);
      check({tag, " adr"}, t.adr, adr);
      if (we) check({tag, " dat"}, t.dat, dat);
      check({tag, " cyc len"}, t.ncyc, slv_dly + 1);
    end
    check({tag, " rsp count"}, rsp_q.size() - rsp_rd, nrsp);
    if (nrsp == 1 && rsp_q.size() > rsp_rd) check({tag, " rsp data"}, rsp_q[rsp_rd], rsp);
    wb_rd  = wb_q.size();
    rsp_rd = rsp_q.size();
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] wdat;
    int         nwb;
    logic       we;
    logic [3:0] adr;
    logic [7:0] dat;
    int         nrsp;
    logic [7:0] rsp;
  } vec_t;

  vec_t tab [9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int         m_nwb, m_nrsp, n;
    logic       m_we;
    logic [3:0] m_adr;
    logic [7:0] m_rsp, d0, c, d;
    bit         stable;

    tab[0] = '{8'h43, 8'h00, 1, 1'b0, 4'h3, 8'h00, 1, 8'h5A};
    tab[1] = '{8'h85, 8'hC3, 1, 1'b1, 4'h5, 8'hC3, 0, 8'h00};
    tab[2] = '{8'h45, 8'h00, 1, 1'b0, 4'h5, 8'h00, 1, 8'hC3};
    tab[3] = '{8'h00, 8'h00, 0, 1'b0, 4'h0, 8'h00, 0, 8'h00};
    tab[4] = '{8'hFF, 8'h00, 0, 1'b0, 4'h0, 8'h00, 0, 8'h00};
    tab[5] = '{8'h3F, 8'h00, 0, 1'b0, 4'h0, 8'h00, 0, 8'h00};
    tab[6] = '{8'h7C, 8'h00, 1, 1'b0, 4'hC, 8'h00, 1, 8'h9E};
    tab[7] = '{8'h80, 8'h00, 1, 1'b1, 4'h0, 8'h00, 0, 8'h00};
    tab[8] = '{8'h40, 8'h00, 1, 1'b0, 4'h0, 8'h00, 1, 8'h00};

    for (int i = 0; i < 16; i++) init_mem[i] = 8'($urandom);
    init_mem[3]  = 8'h5A;
    init_mem[12] = 8'h9E;
    mdl_mem  = init_mem;
    load_mem = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    check("reset outputs",
          {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, handshake_ack, rsp_valid, rsp_data},
          '0);
    repeat (3) @(negedge clk);
    load_mem = 1'b0;
    rst_n    = 1'b1;
    repeat (2) @(negedge clk);

    slv_dly = 2;
    for (int i = 0; i < 9; i++) begin
      model(tab[i].cmd, tab[i].wdat, m_nwb, m_we, m_adr, m_nrsp, m_rsp);
      issue(tab[i].cmd, tab[i].wdat);
      settle(tab[i].nwb, tab[i].nrsp);
      compare($sformatf("vec%0d", i), tab[i].nwb, tab[i].we, tab[i].adr, tab[i].dat,
              tab[i].nrsp, tab[i].rsp);
    end

    // Held response must block the next byte until it is taken.
    rdy_val = 1'b0;
    send_byte(8'h43);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("bp rsp_valid", rsp_valid, 1);
    d0              = rsp_data;
    stable          = 1'b1;
    handshake_data  = 8'h00;
    handshake_valid = 1'b1;
    bytes_sent++;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== d0 || handshake_ack) stable = 1'b0;
    end
    check("bp held", stable, 1);
    check("bp data", d0, mdl_mem[3]);
    rdy_val = 1'b1;
    n = 0;
    while (!handshake_ack && n < 50) begin @(negedge clk); n++; end
    check("bp ack after transfer", handshake_ack, 1);
    check("bp rsp taken once", rsp_q.size() - rsp_rd, 1);
    handshake_valid = 1'b0;
    n = 0;
    while (handshake_ack && n < 50) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    wb_rd  = wb_q.size();
    rsp_rd = rsp_q.size();

    rnd_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      c       = 8'($urandom);
      d       = 8'($urandom);
      slv_dly = $urandom_range(0, 3);
      model(c, d, m_nwb, m_we, m_adr, m_nrsp, m_rsp);
      issue(c, d);
      settle(m_nwb, m_nrsp);
      compare($sformatf("rnd%0d cmd %02h", i, c), m_nwb, m_we, m_adr, d, m_nrsp, m_rsp);
    end
    rnd_mode = 1'b0;
    rdy_val  = 1'b1;

    // Slave that never acks.
    slv_en = 1'b0;
    send_byte(8'h42);
    n = 0;
    while (!wbm_cyc_o && n < 50) begin @(negedge clk); n++; end
    check("stall cyc up", wbm_cyc_o, 1);
`ifdef WBM_SPI_CMD_TIMEOUT_EN
    n = 0;
    while (wbm_cyc_o && n < 200) begin n++; @(negedge clk); end
    check("timeout cyc cycles", n, TMO);
    n = 0;
    while (rsp_q.size() <= rsp_rd && n < 50) begin @(negedge clk); n++; end
    check("timeout rsp count", rsp_q.size() - rsp_rd, 1);
    if (rsp_q.size() > rsp_rd) check("timeout rsp data", rsp_q[rsp_rd], 8'hFF);
    check("timeout no wb ack", wb_q.size() - wb_rd, 0);
    rsp_rd = rsp_q.size();
    repeat (3) @(negedge clk);
    send_byte(8'h42);
    n = 0;
    while (!wbm_cyc_o && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
`else
    repeat (1000) @(negedge clk);
    check("no timeout cyc held", wbm_cyc_o, 1);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("mid reset outputs", {wbm_cyc_o, wbm_stb_o, handshake_ack, rsp_valid}, 4'b0000);
    @(negedge clk);
    rst_n  = 1'b1;
    slv_en = 1'b1;
    slv_dly = 1;
    repeat (2) @(negedge clk);
    wb_rd  = wb_q.size();
    rsp_rd = rsp_q.size();
    model(8'h41, 8'h00, m_nwb, m_we, m_adr, m_nrsp, m_rsp);
    issue(8'h41, 8'h00);
    settle(m_nwb, m_nrsp);
    compare("post reset read", m_nwb, m_we, m_adr, 8'h00, m_nrsp, m_rsp);

    check("ack pulses per byte", ack_rises, bytes_sent);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
